fir_dout_sink: RTL and testbench

Consumer for the FIR compiler output handshake (rdy strobe + 34-bit dout). Rounds and saturates each full-precision filter result to a 16-bit audio/IQ sample, buffers results in a small FIFO, and presents them on a valid/ready stream to the downstream DAC/USB path. Counts saturation and overflow events for debug.

---
 rtl/fir_dout_sink_if.sv | 11 +
 rtl/fir_dout_sink.sv | 163 ++++++++++++++++
 tb/tb_fir_dout_sink.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_dout_sink_if.sv
// Valid/ready sample stream carrying rounded FIR results toward the DAC/USB path.
interface fir_dout_sink_if #(
  parameter int unsigned DW = 16
) ();
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fir_dout_sink.sv
// FIR output consumer: round + saturate each full-precision result to an output sample,
// buffer it in a small first-word-fall-through FIFO and count saturation / drop events.
module fir_dout_sink #(
  parameter int unsigned DIN_W      = 34,
  parameter int unsigned DOUT_W     = 16,
  parameter int unsigned SHIFT      = 9,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy,
  input  logic [DIN_W-1:0]              dout,
  fir_dout_sink_if.master               m,
  input  logic                          clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              sat_cnt,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic                          ovf_flag
);

  localparam int unsigned SUM_W = DIN_W + 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  // Half an output LSB, added before the arithmetic shift for round-half-up.
  localparam logic [SUM_W-1:0]        RND   = SUM_W'(1) << (SHIFT - 1);
  localparam logic signed [SUM_W-1:0] Q_MAX = SUM_W'((1 << (DOUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] Q_MIN = ~Q_MAX;

  // Stage 1 registers
  logic                    s1_valid_q;
  logic signed [SUM_W-1:0] s1_sum_q;

  // Stage 2 combinational result
  logic signed [SUM_W-1:0] q;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [DOUT_W-1:0]       sample;

  // FIFO state
  logic [DOUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;
  logic              full;
  logic              rd_en;
  logic              wr_en;
  logic              drop;

  // Event counters
  logic             sat_ev;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d;

  // Stage 1: sign-extend and add the rounding constant; dout only sampled on rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
    end else begin
      s1_valid_q <= rdy;
      if (rdy) begin
        s1_sum_q <= {dout[DIN_W-1], dout} + RND;
      end
    end
  end

  // Stage 2: arithmetic shift and clamp to the output range.
  always_comb begin
    q      = s1_sum_q >>> SHIFT;
    sat_hi = (q > Q_MAX);
    sat_lo = (q < Q_MIN);
    sample = q[DOUT_W-1:0];
    if (sat_hi) begin
      sample = Q_MAX[DOUT_W-1:0];
    end else if (sat_lo) begin
      sample = Q_MIN[DOUT_W-1:0];
    end
  end

  // FIFO control: a read frees a slot in the same edge, so full+read still accepts a write.
  always_comb begin
    rd_en   = m.valid & m.ready;
    full    = (level_q == LVL_W'(FIFO_DEPTH));
    wr_en   = s1_valid_q & (~full | rd_en);
    drop    = s1_valid_q & full & ~rd_en;
    level_d = level_q;
    if (wr_en && !rd_en) begin
      level_d = level_q + LVL_W'(1);
    end else if (!wr_en && rd_en) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // FIFO storage and pointers; reset discards everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= sample;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  // Counter next-state: saturating increments, clear has priority over events.
  always_comb begin
    sat_ev     = s1_valid_q & (sat_hi | sat_lo);
    sat_cnt_d  = sat_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    if (clr) begin
      sat_cnt_d  = '0;
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (sat_ev && !(&sat_cnt_q)) begin
        sat_cnt_d = sat_cnt_q + CNT_W'(1);
      end
      if (drop && !(&drop_cnt_q)) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sat_cnt_q  <= sat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Head of the FIFO is presented straight from storage flops (fall-through, no bypass).
  assign m.valid    = (level_q != '0);
  assign m.data     = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign sat_cnt    = sat_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_fir_dout_sink.sv
// Scoreboard bench for fir_dout_sink: stimulus pushes expected samples, a negedge monitor
// pops and compares on every accepted output beat.
module tb_fir_dout_sink;

  localparam logic [33:0] IDLE_DOUT = 34'h2_AAAA_AAAA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rdy;
  logic [33:0] dout;
  logic        clr;
  logic [3:0]  fifo_level;
  logic [15:0] sat_cnt;
  logic [15:0] drop_cnt;
  logic        ovf_flag;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  fir_dout_sink_if #(.DW(16)) m_if ();

  fir_dout_sink #(
    .DIN_W(34), .DOUT_W(16), .SHIFT(9), .FIFO_DEPTH(8), .CNT_W(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .dout       (dout),
    .m          (m_if),
    .clr        (clr),
    .fifo_level (fifo_level),
    .sat_cnt    (sat_cnt),
    .drop_cnt   (drop_cnt),
    .ovf_flag   (ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One rdy pulse; expected sample queued only if it should reach the output.
  task automatic send(input logic [33:0] d, input logic [15:0] e, input bit push);
    if (push) exp_q.push_back(e);
    rdy  = 1'b1;
    dout = d;
    @(posedge clk);
    #1;
    rdy  = 1'b0;
    dout = IDLE_DOUT;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: a beat is committed at the next posedge when valid&ready at the negedge.
  always @(negedge clk) begin
    if (rst_n && m_if.valid && m_if.ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected actual=%0h expected=none", m_if.data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (m_if.data !== e) begin
          errors++;
          $display("FAIL beat_data actual=%0h expected=%0h", m_if.data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rdy        = 1'b0;
    dout       = IDLE_DOUT;
    clr        = 1'b0;
    m_if.ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(m_if.valid), 64'd0);
    chk("rst_data", 64'(m_if.data), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_sat", 64'(sat_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_ovf", 64'(ovf_flag), 64'd0);
    rst_n = 1'b1;
    m_if.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Latency: rdy at E1, output visible after E2.
    exp_q.push_back(16'd2);
    rdy  = 1'b1;
    dout = 34'd1000;
    @(posedge clk);
    #1;
    rdy  = 1'b0;
    dout = IDLE_DOUT;
    chk("lat_e1_valid", 64'(m_if.valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_e2_valid", 64'(m_if.valid), 64'd1);
    chk("lat_e2_data", 64'(m_if.data), 64'd2);
    send(-34'sd1000, 16'hFFFE, 1'b1);

    // Rounding, back to back.
    send(34'd255, 16'h0000, 1'b1);
    send(34'd256, 16'h0001, 1'b1);
    send(-34'sd256, 16'h0000, 1'b1);
    send(-34'sd257, 16'hFFFF, 1'b1);
    drain("drain_round");
    chk("round_sat_cnt", 64'(sat_cnt), 64'd0);

    // Saturation.
    send(34'h1_FFFF_FFFF, 16'h7FFF, 1'b1);
    send(34'h2_0000_0000, 16'h8000, 1'b1);
    drain("drain_sat");
    chk("sat_cnt_2", 64'(sat_cnt), 64'd2);

    // Backpressure overflow: 10 samples into 8 slots.
    m_if.ready = 1'b0;
    for (int k = 1; k <= 10; k++) send(34'(512 * k), 16'(k), k <= 8);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_level", 64'(fifo_level), 64'd8);
    chk("bp_drop", 64'(drop_cnt), 64'd2);
    chk("bp_ovf", 64'(ovf_flag), 64'd1);
    chk("bp_hold_valid", 64'(m_if.valid), 64'd1);
    chk("bp_hold_data", 64'(m_if.data), 64'd1);
    m_if.ready = 1'b1;
    drain("drain_bp");
    chk("bp_empty_valid", 64'(m_if.valid), 64'd0);
    chk("bp_empty_level", 64'(fifo_level), 64'd0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    chk("clr_ovf", 64'(ovf_flag), 64'd0);
    chk("clr_sat", 64'(sat_cnt), 64'd0);

    // Full FIFO with a concurrent read and write.
    m_if.ready = 1'b0;
    for (int k = 1; k <= 8; k++) send(34'(512 * k), 16'(k), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("full_level", 64'(fifo_level), 64'd8);
    exp_q.push_back(16'd9);
    rdy  = 1'b1;
    dout = 34'(512 * 9);
    @(posedge clk);
    #1;
    rdy        = 1'b0;
    dout       = IDLE_DOUT;
    m_if.ready = 1'b1;
    @(posedge clk);
    #1;
    m_if.ready = 1'b0;
    chk("fullrw_level", 64'(fifo_level), 64'd8);
    chk("fullrw_drop", 64'(drop_cnt), 64'd0);
    chk("fullrw_ovf", 64'(ovf_flag), 64'd0);
    m_if.ready = 1'b1;
    drain("drain_fullrw");

    // Asynchronous reset mid-stream.
    m_if.ready = 1'b0;
    for (int k = 1; k <= 5; k++) send(34'(512 * k), 16'(k), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_level", 64'(fifo_level), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_if.valid), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    m_if.ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(m_if.valid), 64'd0);
    send(34'd1000, 16'd2, 1'b1);
    drain("drain_post_rst");
    chk("end_drop", 64'(drop_cnt), 64'd0);
    chk("end_sat", 64'(sat_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
